valid_capture_fifo: RTL and testbench
=====================================

VALID_CAPTURE_FIFO -- requirements
Module: valid_capture_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32 (DATA_WIDTH), meaning the data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of storage entries; power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_data, input, WIDTH bits: word from the upstream producer.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle; there is no backpressure to upstream.
REQ-007 SHALL have port out_data, output, WIDTH bits: head-of-queue word.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when a word is dropped.
REQ-012 SHALL have port ovf_clr, input, 1 bit: single-cycle pulse that clears overflow.

Function
REQ-013 SHALL push in_data when in_valid=1 and (count<DEPTH, or a pop occurs in the same cycle).
REQ-014 SHALL pop when out_valid=1 and out_ready=1; out_ready is ignored while out_valid=0.
REQ-015 SHALL drive out_valid = (count!=0) and out_data = storage[rd_ptr], both from registered state only (no combinational in-to-out path).
REQ-016 SHALL have first-word latency of 1 cycle: a push at edge N makes out_valid=1 after edge N; an empty queue with in_valid=1 never bypasses to out_data in the same cycle.
REQ-017 SHALL, on simultaneous push and pop, leave count unchanged; this applies when empty-but-valid, mid-range and full alike.
REQ-018 SHALL, when in_valid=1, count=DEPTH and no pop occurs, drop the word: storage and count unchanged, overflow=1 from the next cycle.
REQ-019 SHALL clear overflow on ovf_clr=1; if a drop and ovf_clr coincide, set wins (overflow stays 1).
REQ-020 SHALL wrap wr_ptr/rd_ptr modulo DEPTH; count saturates at neither end because over- and underflow are impossible by REQ-013/014.
REQ-021 SHALL preserve word order exactly (FIFO); no reordering and no duplication.

Reset
REQ-022 SHALL, on rst_n=0, immediately and asynchronously force out_valid=0, count=0, overflow=0, wr_ptr=rd_ptr=0.
REQ-023 SHALL drive out_data=0 after reset; storage contents SHALL NOT be reset.
REQ-024 SHALL discard in-flight words on reset mid-operation; the first push after release is the next out_data.

Configuration
REQ-025 SHALL, with macro VCF_DROP_CNT_EN defined, add output drop_cnt (16 bits): it counts dropped words, saturates at 16'hFFFF, is cleared by ovf_clr (a coincident drop leaves it at 1), and resets to 0.
REQ-026 SHALL, without VCF_DROP_CNT_EN, omit the drop_cnt port and its logic entirely, with all other behaviour identical.

Structure
REQ-027 SHALL place the DATA_WIDTH/ADDR_WIDTH defaults (32) and the drop-counter width constant (16) in shared package vcf_pkg.
REQ-028 SHALL isolate storage in one sub-module vcf_mem (synchronous write, asynchronous read, no reset); pointer, count and flag control stays in valid_capture_fifo.

Verification
REQ-029 SHALL verify basic order: push 0xA5A5_0001..0xA5A5_0003 with out_ready=0, then out_ready=1 -> out_data is 0001,0002,0003 on consecutive cycles, count 3->0.
REQ-030 SHALL verify latency: empty queue, in_valid=1 with 0xDEAD_BEEF at edge N -> out_valid=0 before N and out_valid=1, out_data=0xDEAD_BEEF after N.
REQ-031 SHALL verify overflow: DEPTH=4, push 5 words (0x10..0x14) with out_ready=0 -> count=4, overflow=1, drop_cnt=1 (if enabled), popped sequence 0x10..0x13.
REQ-032 SHALL verify full with simultaneous push and pop: count=4, in_valid=1 (0x20), out_ready=1 -> no drop, overflow stays 0, count stays 4, 0x20 emerges last.
REQ-033 SHALL verify clear/drop race: drop and ovf_clr in the same cycle -> overflow=1; ovf_clr alone next cycle -> overflow=0, drop_cnt=0.
REQ-034 SHALL verify reset mid-stream: count=3, assert rst_n=0 off-edge -> out_valid=0, count=0 immediately; after release, push 0x55 -> out_data=0x55.

Source files
------------

// File: rtl/vcf_pkg.sv
// rtl/vcf_pkg.sv - shared widths and drop-counter helper for valid_capture_fifo
package vcf_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int ADDR_WIDTH     = 32;
   localparam int DROP_CNT_WIDTH = 16;

   localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

   // Next drop-counter value: a drop coinciding with a clear restarts the count at 1,
   // otherwise drops saturate at all-ones and a lone clear zeroes the counter.
   function automatic logic [DROP_CNT_WIDTH-1:0] drop_cnt_next(
      input logic [DROP_CNT_WIDTH-1:0] cur,
      input logic                      drop,
      input logic                      clr
   );
      if (drop) begin
         if (clr) begin
            return DROP_CNT_WIDTH'(1);
         end
         return (cur == DROP_CNT_MAX) ? cur : cur + DROP_CNT_WIDTH'(1);
      end
      if (clr) begin
         return '0;
      end
      return cur;
   endfunction

endpackage

// File: rtl/vcf_mem.sv
// rtl/vcf_mem.sv - word storage: synchronous write, asynchronous read, no reset
module vcf_mem
   import vcf_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] storage [DEPTH];

   // Write the accepted word into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         storage[wr_addr] <= wr_data;
      end
   end

   assign rd_data = storage[rd_addr];

endmodule

// File: rtl/valid_capture_fifo.sv
// rtl/valid_capture_fifo.sv - capture FIFO for a producer without backpressure; optional drop counter via VCF_DROP_CNT_EN
module valid_capture_fifo
   import vcf_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       ovf_clr
`ifdef VCF_DROP_CNT_EN
   ,
   output logic [DROP_CNT_WIDTH-1:0]  drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] rd_data;
   logic             full;
   logic             push;
   logic             pop;
   logic             drop;

   // A full queue still accepts a word when the consumer frees a slot in the same cycle.
   assign out_valid = (count != '0);
   assign full      = (count == CW'(DEPTH));
   assign pop       = out_valid & out_ready;
   assign push      = in_valid & (~full | pop);
   assign drop      = in_valid & full & ~pop;

   // Storage is never reset, so the head word is masked to zero while the queue is empty.
   assign out_data  = out_valid ? rd_data : '0;

   vcf_mem #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   // Advance the pointers (wrapping modulo DEPTH) and track occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef VCF_DROP_CNT_EN
   // Count dropped words, saturating, cleared together with the overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else begin
         drop_cnt <= drop_cnt_next(drop_cnt, drop, ovf_clr);
      end
   end
`endif

endmodule

// File: tb/tb_valid_capture_fifo.sv
// tb/tb_valid_capture_fifo.sv - queue-model bench for valid_capture_fifo with directed and random traffic
module tb_valid_capture_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             ovf_clr;
`ifdef VCF_DROP_CNT_EN
   logic [15:0]      drop_cnt;
`endif

   always #5 clk = ~clk;

   valid_capture_fifo #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
`ifdef VCF_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   logic [WIDTH-1:0] mq[$];
   bit               m_ovf = 1'b0;
   int               m_drops = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: a plain queue plus flag and drop tally, updated at each rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         int n;
         bit p;
         bit d;
         n = mq.size();
         p = (n != 0) && out_ready;
         d = in_valid && (n == DEPTH) && !p;
         if (p) void'(mq.pop_front());
         if (in_valid && !d) mq.push_back(in_data);
         if (d) m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         if (d) m_drops = ovf_clr ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
         else if (ovf_clr) m_drops = 0;
      end
   end

   // Compare DUT outputs to the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", out_valid, mq.size() != 0);
         check("count", count, mq.size());
         check("overflow", overflow, m_ovf);
         if (mq.size() != 0) check("out_data", out_data, mq[0]);
`ifdef VCF_DROP_CNT_EN
         check("drop_cnt", drop_cnt, m_drops);
`endif
      end
   end

   task automatic step(input bit v, input logic [31:0] d, input bit r, input bit c);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      ovf_clr   = c;
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
   endtask

   initial begin
      logic [31:0] tail_exp [4];
      tail_exp = '{32'h31, 32'h32, 32'h33, 32'h20};
      idle();
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_count", count, 0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_out_data", out_data, 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // basic order
      step(1, 32'hA5A5_0001, 0, 0);
      step(1, 32'hA5A5_0002, 0, 0);
      step(1, 32'hA5A5_0003, 0, 0);
      idle();
      check("order_count3", count, 3);
      check("order_w1", out_data, 32'hA5A5_0001);
      step(0, 0, 1, 0);
      check("order_w2", out_data, 32'hA5A5_0002);
      check("order_count2", count, 2);
      step(0, 0, 1, 0);
      check("order_w3", out_data, 32'hA5A5_0003);
      check("order_count1", count, 1);
      step(0, 0, 1, 0);
      check("order_count0", count, 0);
      check("order_empty", out_valid, 1'b0);

      // first-word latency, no same-cycle bypass
      check("lat_before", out_valid, 1'b0);
      in_valid = 1'b1;
      in_data  = 32'hDEAD_BEEF;
      #1;
      check("lat_no_bypass", out_valid, 1'b0);
      @(negedge clk);
      check("lat_valid", out_valid, 1'b1);
      check("lat_data", out_data, 32'hDEAD_BEEF);
      step(0, 0, 1, 0);
      idle();

      // overflow on the fifth word
      for (int i = 0; i < 5; i++) step(1, 32'h10 + i, 0, 0);
      idle();
      check("ovf_count", count, 4);
      check("ovf_flag", overflow, 1'b1);
`ifdef VCF_DROP_CNT_EN
      check("ovf_drop_cnt", drop_cnt, 1);
`endif
      for (int i = 0; i < 4; i++) begin
         check("ovf_pop_seq", out_data, 32'h10 + i);
         step(0, 0, 1, 0);
      end
      check("ovf_drained", count, 0);
      step(0, 0, 0, 1);
      check("ovf_cleared", overflow, 1'b0);

      // full with simultaneous push and pop
      for (int i = 0; i < 4; i++) step(1, 32'h30 + i, 0, 0);
      step(1, 32'h20, 1, 0);
      idle();
      check("full_pp_count", count, 4);
      check("full_pp_ovf", overflow, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("full_pp_seq", out_data, tail_exp[i]);
         step(0, 0, 1, 0);
      end
      check("full_pp_drained", count, 0);

      // drop and clear in the same cycle
      for (int i = 0; i < 4; i++) step(1, 32'h40 + i, 0, 0);
      step(1, 32'h44, 0, 1);
      check("race_ovf_set", overflow, 1'b1);
`ifdef VCF_DROP_CNT_EN
      check("race_drop_cnt1", drop_cnt, 1);
`endif
      step(0, 0, 0, 1);
      check("race_ovf_clr", overflow, 1'b0);
`ifdef VCF_DROP_CNT_EN
      check("race_drop_cnt0", drop_cnt, 0);
`endif
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      idle();

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) step(1, 32'h50 + i, 0, 0);
      idle();
      check("mid_count3", count, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_count", count, 0);
      check("mid_rst_data", out_data, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 32'h55, 0, 0);
      idle();
      check("mid_first_after", out_data, 32'h55);
      check("mid_count1", count, 1);
      step(0, 0, 1, 0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         int rdy_pct;
         rdy_pct = ((i / 400) % 2 == 1) ? 85 : 30;
         if ($urandom_range(0, 249) == 0) begin
            idle();
            #2;
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < rdy_pct,
              $urandom_range(0, 29) == 0);
      end
      idle();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
